// File: rtl/stack_ctrl.sv
// RAM-backed 8-bit calculator stack controller: push/pop/top/add/sub/clear plus a
// display-address cursor whose value is refreshed from the external synchronous RAM.
module stack_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       op_req,
    input  logic [2:0] op_code,
    input  logic [7:0] din,
    input  logic [7:0] mem_rdata,
    output logic       mem_we,
    output logic [6:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic [6:0] sp,
    output logic [6:0] dar,
    output logic [7:0] dvr,
    output logic       busy,
    output logic       empty,
    output logic       full,
    output logic       err
);

    typedef enum logic [2:0] {
        OP_PUSH  = 3'd0,
        OP_POP   = 3'd1,
        OP_ADD   = 3'd2,
        OP_SUB   = 3'd3,
        OP_TOP   = 3'd4,
        OP_CLEAR = 3'd5,
        OP_DEC   = 3'd6,
        OP_INC   = 3'd7
    } op_t;

    typedef enum logic [3:0] {
        IDLE, PUSH, POP_ADJ, RD, CAP, RD_A, CAP_A, RD_B, CAP_B, WR
    } state_t;

    state_t     r_state;
    logic [6:0] r_sp;
    logic [6:0] r_dar;
    logic [7:0] r_dvr;
    logic       r_err;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic       r_sub;
    logic       r_dar_rd;

    logic [6:0] w_sp_inc;
    logic [7:0] w_result;
    logic       w_empty;
    logic       w_full;
    logic       w_mem_we;
    logic [6:0] w_mem_addr;
    logic [7:0] w_mem_wdata;

    assign w_sp_inc = r_sp + 7'd1;
    assign w_result = r_sub ? (r_b - r_a) : (r_b + r_a);
    assign w_empty  = (r_sp == 7'h7F);
    assign w_full   = (r_sp == 7'h00);

    // Write strobe and address are decoded from state so a reset kills a write instantly.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = r_dar;
        w_mem_wdata = w_result;
        case (r_state)
            PUSH: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = r_sp;
                w_mem_wdata = din;
            end
            RD:          w_mem_addr = r_dar_rd ? r_dar : w_sp_inc;
            RD_A, RD_B:  w_mem_addr = w_sp_inc;
            WR: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = w_sp_inc;
                w_mem_wdata = w_result;
            end
            default: ;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register samples
    // pre-edge values; the RAM itself lives outside this block and is never reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_sp     <= 7'h7F;
            r_dar    <= 7'h00;
            r_dvr    <= 8'h00;
            r_err    <= 1'b0;
            r_a      <= 8'h00;
            r_b      <= 8'h00;
            r_sub    <= 1'b0;
            r_dar_rd <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (op_req) begin
                        case (op_t'(op_code))
                            OP_PUSH: begin
                                if (w_full) r_err   <= 1'b1;
                                else        r_state <= PUSH;
                            end
                            OP_POP: begin
                                r_dar_rd <= 1'b0;
                                if (w_empty) r_err   <= 1'b1;
                                else         r_state <= POP_ADJ;
                            end
                            OP_TOP: begin
                                r_dar_rd <= 1'b0;
                                if (w_empty) r_err   <= 1'b1;
                                else         r_state <= RD;
                            end
                            OP_ADD, OP_SUB: begin
                                r_sub <= (op_t'(op_code) == OP_SUB);
                                if (r_sp > 7'h7D) r_err   <= 1'b1;
                                else              r_state <= RD_A;
                            end
                            OP_CLEAR: begin
                                r_sp  <= 7'h7F;
                                r_dar <= 7'h00;
                                r_dvr <= 8'h00;
                            end
                            OP_DEC: begin
                                r_dar    <= r_dar - 7'd1;
                                r_dar_rd <= 1'b1;
                                r_state  <= RD;
                            end
                            OP_INC: begin
                                r_dar    <= r_dar + 7'd1;
                                r_dar_rd <= 1'b1;
                                r_state  <= RD;
                            end
                            default: ;
                        endcase
                    end
                end
                PUSH: begin
                    r_sp    <= r_sp - 7'd1;
                    r_dar   <= r_sp;
                    r_dvr   <= din;
                    r_state <= IDLE;
                end
                POP_ADJ: begin
                    r_sp    <= w_sp_inc;
                    r_state <= RD;
                end
                RD: begin
                    // Popping the last entry leaves nothing to show, so the display blanks.
                    if (!r_dar_rd && w_empty) begin
                        r_dar   <= 7'h00;
                        r_dvr   <= 8'h00;
                        r_state <= IDLE;
                    end else begin
                        if (!r_dar_rd) r_dar <= w_sp_inc;
                        r_state <= CAP;
                    end
                end
                CAP: begin
                    r_dvr   <= mem_rdata;
                    r_state <= IDLE;
                end
                RD_A:  r_state <= CAP_A;
                CAP_A: begin
                    r_a     <= mem_rdata;
                    r_sp    <= w_sp_inc;
                    r_state <= RD_B;
                end
                RD_B:  r_state <= CAP_B;
                CAP_B: begin
                    r_b     <= mem_rdata;
                    r_state <= WR;
                end
                WR: begin
                    r_dar   <= w_sp_inc;
                    r_dvr   <= w_result;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_we    = w_mem_we;
    assign mem_addr  = w_mem_addr;
    assign mem_wdata = w_mem_wdata;
    assign sp        = r_sp;
    assign dar       = r_dar;
    assign dvr       = r_dvr;
    assign busy      = (r_state != IDLE);
    assign empty     = w_empty;
    assign full      = w_full;
    assign err       = r_err;

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with a synchronous 128x8 RAM model; each scenario
// task drives commands and compares against hand-computed values.
module tb_stack_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       op_req = 1'b0;
    logic [2:0] op_code = 3'd0;
    logic [7:0] din = 8'h00;
    logic [7:0] mem_rdata = 8'h00;
    logic       mem_we;
    logic [6:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [6:0] sp;
    logic [6:0] dar;
    logic [7:0] dvr;
    logic       busy;
    logic       empty;
    logic       full;
    logic       err;

    localparam logic [2:0] C_PUSH = 3'd0, C_POP = 3'd1, C_ADD = 3'd2, C_SUB = 3'd3,
                           C_TOP = 3'd4, C_CLEAR = 3'd5, C_DEC = 3'd6, C_INC = 3'd7;

    stack_ctrl dut (
        .clk(clk), .rst_n(rst_n), .op_req(op_req), .op_code(op_code), .din(din),
        .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .sp(sp), .dar(dar), .dvr(dvr), .busy(busy), .empty(empty), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [128] = '{default: 8'h5A};
    int         wr_cnt = 0;
    logic [6:0] wr_addr = 7'h00;
    logic [7:0] wr_data = 8'h00;

    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            wr_cnt        <= wr_cnt + 1;
            wr_addr       <= mem_addr;
            wr_data       <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    int checks = 0;
    int passed = 0;
    int bc;
    bit se;
    int w0;

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        op_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One command strobe; returns busy-cycle count and whether err was seen.
    task automatic issue(input logic [2:0] op, input logic [7:0] d,
                         output int busy_cyc, output bit saw_err);
        @(negedge clk);
        op_req  = 1'b1;
        op_code = op;
        din     = d;
        @(negedge clk);
        op_req   = 1'b0;
        busy_cyc = 0;
        saw_err  = err;
        while (busy && busy_cyc < 20) begin
            busy_cyc++;
            @(negedge clk);
            if (err) saw_err = 1'b1;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (sp !== 7'h7F) $display("FAIL rst_sp: got %h want 7f", sp); else passed++;
        checks++; if (dar !== 7'h00 || dvr !== 8'h00) $display("FAIL rst_dar_dvr: got %h/%h want 00/00", dar, dvr); else passed++;
        checks++; if (busy !== 1'b0 || err !== 1'b0 || mem_we !== 1'b0) $display("FAIL rst_ctl: busy/err/we got %b%b%b want 000", busy, err, mem_we); else passed++;
        checks++; if (empty !== 1'b1 || full !== 1'b0) $display("FAIL rst_flags: empty/full got %b%b want 10", empty, full); else passed++;
        // First edge after release must accept a command.
        @(negedge clk);
        rst_n   = 1'b1;
        op_req  = 1'b1;
        op_code = C_PUSH;
        din     = 8'h66;
        @(negedge clk);
        op_req = 1'b0;
        checks++; if (busy !== 1'b1 || mem_we !== 1'b1) $display("FAIL rst_first_accept: busy/we got %b%b want 11", busy, mem_we); else passed++;
        @(negedge clk);
    endtask

    task automatic test_push_sub();
        do_reset();
        w0 = wr_cnt;
        issue(C_PUSH, 8'h05, bc, se);
        checks++; if (bc !== 1 || wr_addr !== 7'h7F || wr_data !== 8'h05) $display("FAIL push1: busy %0d wr %h,%h want 1 7f,05", bc, wr_addr, wr_data); else passed++;
        issue(C_PUSH, 8'h03, bc, se);
        checks++; if (wr_addr !== 7'h7E || wr_data !== 8'h03 || wr_cnt - w0 !== 2) $display("FAIL push2_wr: got %h,%h n=%0d want 7e,03 n=2", wr_addr, wr_data, wr_cnt - w0); else passed++;
        checks++; if (sp !== 7'h7D || dar !== 7'h7E || dvr !== 8'h03 || empty !== 1'b0) $display("FAIL push2_regs: sp/dar/dvr/empty got %h/%h/%h/%b want 7d/7e/03/0", sp, dar, dvr, empty); else passed++;
        issue(C_SUB, 8'h00, bc, se);
        checks++; if (bc !== 5 || se !== 1'b0) $display("FAIL sub_busy: got %0d err %b want 5 err 0", bc, se); else passed++;
        checks++; if (wr_addr !== 7'h7F || wr_data !== 8'h02 || wr_cnt - w0 !== 3) $display("FAIL sub_wr: got %h,%h n=%0d want 7f,02 n=3", wr_addr, wr_data, wr_cnt - w0); else passed++;
        checks++; if (sp !== 7'h7E || dar !== 7'h7F || dvr !== 8'h02) $display("FAIL sub_regs: sp/dar/dvr got %h/%h/%h want 7e/7f/02", sp, dar, dvr); else passed++;
        issue(C_ADD, 8'h00, bc, se);
        checks++; if (se !== 1'b1 || bc !== 0) $display("FAIL add_reject: err %b busy %0d want 1 0", se, bc); else passed++;
        checks++; if (sp !== 7'h7E || dar !== 7'h7F || dvr !== 8'h02 || wr_cnt - w0 !== 3) $display("FAIL add_reject_state: sp/dar/dvr %h/%h/%h n=%0d want 7e/7f/02 n=3", sp, dar, dvr, wr_cnt - w0); else passed++;
    endtask

    task automatic test_fill();
        do_reset();
        w0 = wr_cnt;
        issue(C_POP, 8'h00, bc, se);
        checks++; if (se !== 1'b1 || bc !== 0) $display("FAIL pop_empty: err %b busy %0d want 1 0", se, bc); else passed++;
        issue(C_TOP, 8'h00, bc, se);
        checks++; if (se !== 1'b1 || bc !== 0 || wr_cnt !== w0) $display("FAIL top_empty: err %b busy %0d writes %0d want 1 0 0", se, bc, wr_cnt - w0); else passed++;
        for (int i = 0; i < 127; i++) issue(C_PUSH, 8'(i), bc, se);
        checks++; if (full !== 1'b1 || sp !== 7'h00 || wr_cnt - w0 !== 127) $display("FAIL fill: full %b sp %h writes %0d want 1 00 127", full, sp, wr_cnt - w0); else passed++;
        checks++; if (dar !== 7'h01 || dvr !== 8'h7E) $display("FAIL fill_disp: dar/dvr %h/%h want 01/7e", dar, dvr); else passed++;
        issue(C_PUSH, 8'hAA, bc, se);
        checks++; if (se !== 1'b1 || wr_cnt - w0 !== 127 || sp !== 7'h00 || dvr !== 8'h7E) $display("FAIL push_full: err %b writes %0d sp %h dvr %h want 1 127 00 7e", se, wr_cnt - w0, sp, dvr); else passed++;
        issue(C_POP, 8'h00, bc, se);
        checks++; if (bc !== 3 || sp !== 7'h01 || dar !== 7'h02 || dvr !== 8'h7D) $display("FAIL pop_full: busy %0d sp/dar/dvr %h/%h/%h want 3 01/02/7d", bc, sp, dar, dvr); else passed++;
    endtask

    task automatic test_wrap();
        do_reset();
        issue(C_PUSH, 8'hFF, bc, se);
        issue(C_PUSH, 8'h01, bc, se);
        issue(C_ADD, 8'h00, bc, se);
        checks++; if (dvr !== 8'h00 || ram[7'h7F] !== 8'h00 || sp !== 7'h7E) $display("FAIL add_wrap: dvr %h mem7f %h sp %h want 00 00 7e", dvr, ram[7'h7F], sp); else passed++;
        issue(C_PUSH, 8'h01, bc, se);
        issue(C_SUB, 8'h00, bc, se);
        checks++; if (dvr !== 8'hFF || wr_addr !== 7'h7F || wr_data !== 8'hFF) $display("FAIL sub_wrap: dvr %h wr %h,%h want ff 7f,ff", dvr, wr_addr, wr_data); else passed++;
        issue(C_TOP, 8'h00, bc, se);
        checks++; if (bc !== 2 || sp !== 7'h7E || dar !== 7'h7F || dvr !== 8'hFF) $display("FAIL top: busy %0d sp/dar/dvr %h/%h/%h want 2 7e/7f/ff", bc, sp, dar, dvr); else passed++;
        issue(C_POP, 8'h00, bc, se);
        checks++; if (bc !== 2 || sp !== 7'h7F || dar !== 7'h00 || dvr !== 8'h00) $display("FAIL pop_last: busy %0d sp/dar/dvr %h/%h/%h want 2 7f/00/00", bc, sp, dar, dvr); else passed++;
    endtask

    task automatic test_addr();
        do_reset();
        issue(C_PUSH, 8'h11, bc, se);
        issue(C_INC, 8'h00, bc, se);
        checks++; if (bc !== 2 || dar !== 7'h00 || dvr !== 8'h5A || sp !== 7'h7E) $display("FAIL inc_wrap: busy %0d dar/dvr/sp %h/%h/%h want 2 00/5a/7e", bc, dar, dvr, sp); else passed++;
        issue(C_DEC, 8'h00, bc, se);
        checks++; if (bc !== 2 || dar !== 7'h7F || dvr !== 8'h11) $display("FAIL dec_wrap: busy %0d dar/dvr %h/%h want 2 7f/11", bc, dar, dvr); else passed++;
        // Keep requesting DEC_ADDR while the INC is still busy; those must vanish.
        se = 1'b0;
        @(negedge clk);
        op_req  = 1'b1;
        op_code = C_INC;
        @(negedge clk);
        op_code = C_DEC;
        if (err) se = 1'b1;
        @(negedge clk);
        if (err) se = 1'b1;
        @(negedge clk);
        op_req = 1'b0;
        if (err) se = 1'b1;
        checks++; if (busy !== 1'b0 || dar !== 7'h00 || dvr !== 8'h5A || sp !== 7'h7E || se !== 1'b0) $display("FAIL busy_drop: busy %b dar/dvr/sp %h/%h/%h err %b want 0 00/5a/7e 0", busy, dar, dvr, sp, se); else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        issue(C_PUSH, 8'h10, bc, se);
        issue(C_PUSH, 8'h20, bc, se);
        w0 = wr_cnt;
        @(negedge clk);
        op_req  = 1'b1;
        op_code = C_ADD;
        @(negedge clk);
        op_req = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1) $display("FAIL mid_busy: got %b want 1", busy); else passed++;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || mem_we !== 1'b0 || sp !== 7'h7F || dvr !== 8'h00) $display("FAIL mid_reset: busy/we %b%b sp %h dvr %h want 00 7f 00", busy, mem_we, sp, dvr); else passed++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (ram[7'h7E] !== 8'h20 || ram[7'h7F] !== 8'h10 || wr_cnt !== w0) $display("FAIL mid_nowrite: mem7e %h mem7f %h writes %0d want 20 10 0", ram[7'h7E], ram[7'h7F], wr_cnt - w0); else passed++;
    endtask

    task automatic test_clear();
        do_reset();
        issue(C_PUSH, 8'h44, bc, se);
        w0 = wr_cnt;
        issue(C_CLEAR, 8'h00, bc, se);
        checks++; if (bc !== 0 || se !== 1'b0 || wr_cnt !== w0) $display("FAIL clear_ctl: busy %0d err %b writes %0d want 0 0 0", bc, se, wr_cnt - w0); else passed++;
        checks++; if (sp !== 7'h7F || dar !== 7'h00 || dvr !== 8'h00 || empty !== 1'b1) $display("FAIL clear_regs: sp/dar/dvr/empty %h/%h/%h/%b want 7f/00/00/1", sp, dar, dvr, empty); else passed++;
    endtask

    initial begin
        test_reset();
        test_push_sub();
        test_fill();
        test_wrap();
        test_addr();
        test_reset_mid();
        test_clear();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
